// File: rtl/gate_chk_pkg.sv
// Shared types for the gate response checker.
// func_e  : reference gate selector (matches the 2-bit func port encoding).
// state_e : checker FSM states.
// gate_ref: pure reference model of the selected 2-input gate.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    FN_AND  = 2'd0,
    FN_OR   = 2'd1,
    FN_XOR  = 2'd2,
    FN_NAND = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic gate_ref(func_e f, logic a, logic b);
    logic r;
    case (f)
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_response_checker_ref.sv
// gate_ref_model: combinational wrapper around gate_ref so benches and other
// checkers can drop in the same reference without importing the function.
// Ports: func (gate select), a, b (gate inputs), exp_o (expected output).
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [1:0] func,
  input  logic       a,
  input  logic       b,
  output logic       exp_o
);

  assign exp_o = gate_ref(func_e'(func), a, b);

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: samples (a,b,out) from a 2-input gate under test and
// checks each triple against the latched reference function. Tracks truth
// table coverage, a saturating mismatch count and the first failing vector;
// finishes on full coverage or on an idle timeout.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, func       begin a run (IDLE/DONE only), reference function
//   vld, a, b, out    sample strobe and sampled triple
//   busy, done        RUN / DONE state indications
//   pass, timeout     run verdict (valid with done)
//   err_cnt, cov      mismatch count, per-{a,b} coverage bits
//   ff_vld, ff_vec    first-fail capture valid and {a,b,out}
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int ERR_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           func,
  input  logic                 vld,
  input  logic                 a,
  input  logic                 b,
  input  logic                 out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [3:0]           cov,
  output logic                 ff_vld,
  output logic [2:0]           ff_vec
);

  // Idle counter only needs to reach TIMEOUT_CYC-1.
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  state_e                 state_q, state_d;
  func_e                  func_q, func_d;
  logic [3:0]             cov_q, cov_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   ff_vld_q, ff_vld_d;
  logic [2:0]             ff_vec_q, ff_vec_d;
  logic                   pass_q, pass_d;
  logic                   timeout_q, timeout_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;

  logic       exp_bit;
  logic       mismatch;
  logic [3:0] cov_hit;

  gate_ref_model u_ref (
    .func  (func_q),
    .a     (a),
    .b     (b),
    .exp_o (exp_bit)
  );

  assign mismatch = (out != exp_bit);
  assign cov_hit  = 4'b0001 << {a, b};

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    cov_d      = cov_q;
    err_cnt_d  = err_cnt_q;
    ff_vld_d   = ff_vld_q;
    ff_vec_d   = ff_vec_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    idle_cnt_d = idle_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          func_d     = func_e'(func);
          cov_d      = '0;
          err_cnt_d  = '0;
          ff_vld_d   = 1'b0;
          ff_vec_d   = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          idle_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (vld) begin
          cov_d      = cov_q | cov_hit;
          idle_cnt_d = '0;
          if (mismatch) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
            if (!ff_vld_q) begin
              ff_vld_d = 1'b1;
              ff_vec_d = {a, b, out};
            end
          end
          // Verdict uses the post-update count so a bad final sample counts.
          // Saturation never wraps to zero, so ==0 means no mismatch at all.
          if ((cov_q | cov_hit) == 4'b1111) begin
            state_d = S_DONE;
            pass_d  = (err_cnt_d == '0);
          end
        end else if (TIMEOUT_CYC > 0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      func_q     <= FN_AND;
      cov_q      <= '0;
      err_cnt_q  <= '0;
      ff_vld_q   <= 1'b0;
      ff_vec_q   <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      cov_q      <= cov_d;
      err_cnt_q  <= err_cnt_d;
      ff_vld_q   <= ff_vld_d;
      ff_vec_q   <= ff_vec_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign err_cnt = err_cnt_q;
  assign cov     = cov_q;
  assign ff_vld  = ff_vld_q;
  assign ff_vec  = ff_vec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: expected run verdicts are queued as each
// run is stimulated and popped/compared when done rises.
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] func = 2'd0;
  logic       vld = 1'b0;
  logic       a = 1'b0, b = 1'b0, out = 1'b0;

  logic       busy, done, pass, timeout, ff_vld;
  logic [7:0] err_cnt;
  logic [3:0] cov;
  logic [2:0] ff_vec;

  // Narrow-counter instance on the same stimulus for the saturation case.
  logic       s_busy, s_done, s_pass, s_timeout, s_ff_vld;
  logic [1:0] s_err_cnt;
  logic [3:0] s_cov;
  logic [2:0] s_ff_vec;

  gate_response_checker #(.ERR_CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .vld(vld),
    .a(a), .b(b), .out(out), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .cov(cov), .ff_vld(ff_vld),
    .ff_vec(ff_vec)
  );

  gate_response_checker #(.ERR_CNT_W(2), .TIMEOUT_CYC(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .vld(vld),
    .a(a), .b(b), .out(out), .busy(s_busy), .done(s_done), .pass(s_pass),
    .timeout(s_timeout), .err_cnt(s_err_cnt), .cov(s_cov), .ff_vld(s_ff_vld),
    .ff_vec(s_ff_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pass;
    logic       tmo;
    logic [7:0] err;
    logic [3:0] cov;
    logic       ffv;
    logic [2:0] ffvec;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] f);
    func  = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic smp(input logic ia, input logic ib, input logic io);
    vld = 1'b1; a = ia; b = ib; out = io;
    tick();
    vld = 1'b0;
  endtask

  task automatic push(input logic p, input logic t, input logic [7:0] e,
                      input logic [3:0] c, input logic fv, input logic [2:0] fvec);
    exp_t x;
    x.pass = p; x.tmo = t; x.err = e; x.cov = c; x.ffv = fv; x.ffvec = fvec;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string tag);
    exp_t x;
    for (int i = 0; i < 64 && !done; i++) tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_pass"},    pass,    x.pass);
      chk({tag, "_timeout"}, timeout, x.tmo);
      chk({tag, "_err_cnt"}, err_cnt, x.err);
      chk({tag, "_cov"},     cov,     x.cov);
      chk({tag, "_ff_vld"},  ff_vld,  x.ffv);
      if (x.ffv) chk({tag, "_ff_vec"}, ff_vec, x.ffvec);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    busy,    1'b0);
    chk({tag, "_done"},    done,    1'b0);
    chk({tag, "_pass"},    pass,    1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_err_cnt"}, err_cnt, 8'd0);
    chk({tag, "_cov"},     cov,     4'd0);
    chk({tag, "_ff_vld"},  ff_vld,  1'b0);
    chk({tag, "_ff_vec"},  ff_vec,  3'd0);
  endtask

  task automatic or_sweep(input string tag);
    go(2'd1);
    chk({tag, "_busy_run"}, busy, 1'b1);
    push(1'b1, 1'b0, 8'd0, 4'hF, 1'b0, 3'd0);
    smp(0, 0, 0); smp(0, 1, 1); smp(1, 0, 1);
    chk({tag, "_not_done_3"}, done, 1'b0);
    smp(1, 1, 1);
    chk({tag, "_latency"}, done, 1'b1);
    wait_done(tag);
  endtask

  initial begin
    // Reset state
    #12;
    chk_zero("rst");
    rst_n = 1'b1;
    tick();

    // Samples before any start are ignored
    smp(0, 0, 1); smp(1, 1, 0);
    chk_zero("idle_vld");

    // OR clean sweep
    or_sweep("or");

    // AND with stuck-at-1-ish faulty DUT: (0,1,1) and (1,0,1) are wrong
    go(2'd0);
    push(1'b0, 1'b0, 8'd2, 4'hF, 1'b1, 3'b011);
    smp(0, 0, 0); smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 1);
    chk("and_latency", done, 1'b1);
    wait_done("and");

    // XOR with a repeat and func toggled mid-run
    go(2'd2);
    func = 2'd0;
    push(1'b1, 1'b0, 8'd0, 4'hF, 1'b0, 3'd0);
    smp(0, 0, 0); smp(0, 0, 0);
    func = 2'd3;
    smp(0, 1, 1); smp(1, 0, 1);
    chk("xor_not_done_4", done, 1'b0);
    chk("xor_cov_4", cov, 4'b0111);
    smp(1, 1, 0);
    chk("xor_latency", done, 1'b1);
    wait_done("xor");

    // Timeout: 2 good OR samples then idle
    go(2'd1);
    push(1'b0, 1'b1, 8'd0, 4'b0011, 1'b0, 3'd0);
    smp(0, 0, 0); smp(0, 1, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", done, 1'b0);
    tick();
    chk("tmo_at_16", done, 1'b1);
    wait_done("tmo");

    // Saturation: NAND, 6 wrong samples, 4th combination last
    go(2'd3);
    push(1'b0, 1'b0, 8'd6, 4'hF, 1'b1, 3'b000);
    smp(0, 0, 0); smp(0, 1, 0); smp(1, 0, 0);
    smp(0, 0, 0); smp(0, 1, 0);
    chk("sat_not_done_5", done, 1'b0);
    smp(1, 1, 1);
    wait_done("sat");
    chk("sat_narrow_err", s_err_cnt, 2'd3);
    chk("sat_narrow_ffvec", s_ff_vec, 3'b000);
    chk("sat_narrow_ffvld", s_ff_vld, 1'b1);
    chk("sat_narrow_pass", s_pass, 1'b0);
    chk("sat_narrow_done", s_done, 1'b1);

    // Reset mid-run, asynchronous, then a clean sweep
    go(2'd1);
    smp(0, 0, 1); smp(0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    #4;
    tick();
    rst_n = 1'b1;
    tick();
    or_sweep("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable response checker for 2-input gate DUTs: the checking end of the gate stimulus flow. It samples (a, b, out) triples from a gate under test and compares each against a selected reference function. It tracks truth-table coverage, counts mismatches and captures the first failing vector. It reports pass/fail once all four input combinations are seen, or on timeout.

Parameters:
ERR_CNT_W, 8, width of the saturating mismatch counter.
TIMEOUT_CYC, 16, max idle cycles in RUN between valid samples before abort; 0 disables timeout.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a check run (accepted in IDLE or DONE only).
func  input  2  reference function: 0 AND, 1 OR, 2 XOR, 3 NAND; latched on accepted start.
vld  input  1  sample strobe; a/b/out valid this cycle.
a  input  1  DUT input a as driven.
b  input  1  DUT input b as driven.
out  input  1  DUT output observed.
busy  output  1  high in RUN.
done  output  1  high in DONE (level, held until next start).
pass  output  1  valid when done: full coverage, zero mismatches, no timeout.
timeout  output  1  run aborted by idle timeout; valid when done.
err_cnt  output  ERR_CNT_W  mismatch count, saturating.
cov  output  4  bit {a,b} set once that combination has been sampled.
ff_vld  output  1  first-fail capture valid.
ff_vec  output  3  first failing {a,b,out}.

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, rst_n low) -> IDLE. All outputs 0, latched func 0, idle counter 0.
- IDLE/DONE + start=1 -> RUN on the next edge. On that edge: latch func, clear cov, err_cnt, ff_vld, ff_vec, timeout, pass and idle counter. done drops and busy rises.
- start in RUN: ignored. func changes in RUN: ignored (the latched value is used).
- vld in IDLE/DONE: ignored, with no effect on any output.
- RUN + vld=1: exp = f_latched(a,b); mismatch = (out != exp). All updates are registered and visible one cycle after the sampling edge:
  - cov[{a,b}] <= 1.
  - On mismatch, err_cnt increments, saturating at 2^ERR_CNT_W-1.
  - On mismatch with ff_vld=0: ff_vec <= {a,b,out} and ff_vld <= 1. Later mismatches never overwrite the capture.
  - Idle counter clears.
- Completion: if (cov | onehot({a,b})) == 4'b1111 on a RUN vld edge, go to DONE on the same edge.
  - done=1 and busy=0.
  - pass <= (err_cnt_next == 0). A mismatch on the final sample is included.
- Repeated combinations are allowed: they are re-checked and counted, and coverage is unchanged.
- Timeout (TIMEOUT_CYC>0): in RUN with vld=0, the idle counter increments. When it reaches TIMEOUT_CYC-1 with vld=0:
  - next state DONE, timeout <= 1, pass <= 0.
  - cov, err_cnt and ff_* hold.
  - A vld in that same cycle takes priority and resets the counter.
- Sample-to-done latency: 1 clock after the last covering sample.
- Reset mid-run: immediate return to IDLE and full clear; no partial results are retained.
- Back-to-back vld every cycle is supported. A minimal full run is start plus 4 samples, with done asserted after 1+4 edges.

Decomposition:
- Package gate_chk_pkg: func_e enum (FN_AND, FN_OR, FN_XOR, FN_NAND), state_e enum (S_IDLE, S_RUN, S_DONE), and the pure function gate_ref(func_e, a, b) returning the expected bit.
- One natural sub-module: gate_ref_model, a combinational wrapper around gate_ref. It is reused by later checkers and benches.
- Top-level FSM, counters and capture registers stay in gate_response_checker.

Test Plan:
- OR clean sweep: start with func=1. Feed vld with (a,b,out) = (0,0,0), (0,1,1), (1,0,1), (1,1,1) on consecutive cycles. Expected: cov=1111, done=1 and pass=1 one cycle after the 4th sample, err_cnt=0, ff_vld=0, timeout=0.
- Stuck-at fault: func=0 (AND). Feed (0,0,0), (0,1,1), (1,0,1), (1,1,1). Expected: err_cnt=2, ff_vec=3'b011, ff_vld=1, done=1, pass=0.
- Repeats and ignored inputs:
  - vld before start: outputs stay 0.
  - Then func=2 (XOR) with samples (0,0,0), (0,0,0), (0,1,1), (1,0,1), (1,1,0). Expected: done only after the 5th sample, pass=1.
  - Toggling func mid-run has no effect.
- Timeout: TIMEOUT_CYC=16. Start, send 2 correct samples, then hold vld=0. Expected: done=1, timeout=1, pass=0 after 16 idle cycles, cov=0011 or equivalent.
- Saturation: ERR_CNT_W=2, func=3 (NAND). Send 6 wrong samples covering all 4 combinations last. Expected: err_cnt=3 (saturated), ff_vec equals the first bad triple.
- Reset mid-run: assert rst_n=0 asynchronously after 2 samples. Expected: all outputs 0 immediately. After release and a new start, a clean OR sweep gives pass=1.
